// File: rtl/top.sv
`default_nettype none
// ----------------------------------------------------------------------------
// top : UART-driven unsigned matrix multiplier, returns C = A x B over 8N1 tx.
// Rev 1.0
// ----------------------------------------------------------------------------
module top #(
  parameter int CLK_HZ = 50000000,
  parameter int MAX_N  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] b_sel,
  output logic       tx
);
  localparam int c_cw = $clog2(CLK_HZ / 2400 + 1);
  localparam int c_nw = $clog2(MAX_N + 1);
  localparam int c_iw = $clog2(MAX_N * MAX_N + 1);
  localparam int c_nn = MAX_N * MAX_N;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [2:0] {WAIT_N, LOAD_A, LOAD_B, COMPUTE, SEND} main_state_t;

  logic [c_cw-1:0] w_period, w_half;
  always_comb begin
    case (b_sel)
      2'b00:   w_period = c_cw'(CLK_HZ / 2400);
      2'b01:   w_period = c_cw'(CLK_HZ / 4800);
      2'b10:   w_period = c_cw'(CLK_HZ / 9600);
      default: w_period = c_cw'(CLK_HZ / 19200);
    endcase
  end
  assign w_half = w_period >> 1;

  // ---------------- receiver ----------------
  rx_state_t       r_rx_state, w_rx_next;
  logic [1:0]      r_sync;
  logic            r_rx_d, r_rx_valid;
  logic [c_cw-1:0] r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_sh;
  logic            w_rx, w_rx_tick;

  assign w_rx      = r_sync[1];
  assign w_rx_tick = (r_rx_cnt == ((r_rx_state == R_START) ? w_half - 1'b1 : w_period - 1'b1));

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      R_IDLE:  if (r_rx_d && !w_rx) w_rx_next = R_START;
      R_START: if (w_rx_tick) w_rx_next = w_rx ? R_IDLE : R_DATA;
      R_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = R_STOP;
      default: if (w_rx_tick) w_rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state <= R_IDLE;
      r_sync     <= 2'b11;
      r_rx_d     <= 1'b1;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_sync     <= {r_sync[0], rx};
      r_rx_d     <= w_rx;
      r_rx_valid <= 1'b0;
      r_rx_cnt   <= (r_rx_state == R_IDLE || w_rx_tick) ? '0 : r_rx_cnt + 1'b1;
      if (w_rx_tick) begin
        case (r_rx_state)
          R_START: r_rx_bit <= '0;
          R_DATA: begin
            r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
            r_rx_bit <= r_rx_bit + 1'b1;
          end
          R_STOP:  r_rx_valid <= w_rx;   // low stop bit drops the byte
          default: ;
        endcase
      end
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t       r_tx_state, w_tx_next;
  logic [c_cw-1:0] r_tx_cnt;
  logic [2:0]      r_tx_bit;
  logic [7:0]      r_tx_sh;
  logic            r_tx_line;
  logic            w_tx_tick, w_tx_ready, w_tx_go;
  logic [7:0]      w_tx_data;

  assign w_tx_tick  = (r_tx_cnt == w_period - 1'b1);
  // Ready on the last stop-bit clock so frames run back to back.
  assign w_tx_ready = (r_tx_state == T_IDLE) || (r_tx_state == T_STOP && w_tx_tick);
  assign tx         = r_tx_line;

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      T_IDLE:  if (w_tx_go) w_tx_next = T_START;
      T_START: if (w_tx_tick) w_tx_next = T_DATA;
      T_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = T_STOP;
      default: if (w_tx_tick) w_tx_next = w_tx_go ? T_START : T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= T_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_cnt   <= (r_tx_state == T_IDLE || w_tx_tick) ? '0 : r_tx_cnt + 1'b1;
      if (w_tx_ready && w_tx_go) begin
        r_tx_sh   <= w_tx_data;
        r_tx_line <= 1'b0;
      end else if (w_tx_tick) begin
        case (r_tx_state)
          T_START: begin
            r_tx_line <= r_tx_sh[0];
            r_tx_bit  <= '0;
          end
          T_DATA: begin
            r_tx_line <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_sh[1];
            r_tx_sh   <= r_tx_sh >> 1;
            r_tx_bit  <= r_tx_bit + 1'b1;
          end
          default: r_tx_line <= 1'b1;
        endcase
      end
    end
  end

  // ---------------- control and datapath ----------------
  main_state_t     r_state, w_next;
  logic [c_nw-1:0] r_n, r_i, r_j, r_k;
  logic [c_iw-1:0] r_nn, r_idx;
  logic [23:0]     r_acc;
  logic [1:0]      r_bsel;
  logic            r_last;
  logic [7:0]      r_mem_a [c_nn];
  logic [7:0]      r_mem_b [c_nn];
  logic [23:0]     r_mem_c [c_nn];
  logic            w_n_ok, w_load_end, w_k_end, w_j_end, w_i_end;
  logic [c_iw-1:0] w_a_addr, w_b_addr, w_c_addr;
  logic [15:0]     w_prod;
  logic [23:0]     w_mac, w_cur_c;

  assign w_n_ok     = (r_rx_sh != 8'd0) && (r_rx_sh <= 8'(MAX_N));
  assign w_load_end = (r_idx == r_nn - 1'b1);
  assign w_k_end    = (r_k == r_n - 1'b1);
  assign w_j_end    = (r_j == r_n - 1'b1);
  assign w_i_end    = (r_i == r_n - 1'b1);
  assign w_a_addr   = c_iw'(r_i) * c_iw'(r_n) + c_iw'(r_k);
  assign w_b_addr   = c_iw'(r_k) * c_iw'(r_n) + c_iw'(r_j);
  assign w_c_addr   = c_iw'(r_i) * c_iw'(r_n) + c_iw'(r_j);
  assign w_prod     = r_mem_a[w_a_addr] * r_mem_b[w_b_addr];
  assign w_mac      = r_acc + {8'd0, w_prod};
  assign w_cur_c    = r_mem_c[r_idx];
  assign w_tx_go    = (r_state == SEND) && !r_last;

  always_comb begin
    case (r_bsel)
      2'd0:    w_tx_data = w_cur_c[23:16];
      2'd1:    w_tx_data = w_cur_c[15:8];
      default: w_tx_data = w_cur_c[7:0];
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_N:  if (r_rx_valid && w_n_ok) w_next = LOAD_A;
      LOAD_A:  if (r_rx_valid && w_load_end) w_next = LOAD_B;
      LOAD_B:  if (r_rx_valid && w_load_end) w_next = COMPUTE;
      COMPUTE: if (w_k_end && w_j_end && w_i_end) w_next = SEND;
      SEND:    if (r_last && w_tx_ready) w_next = WAIT_N;
      default: w_next = WAIT_N;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= WAIT_N;
      r_n     <= '0;
      r_nn    <= '0;
      r_idx   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_bsel  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        WAIT_N: if (r_rx_valid && w_n_ok) begin
          r_n    <= r_rx_sh[c_nw-1:0];
          r_nn   <= c_iw'(r_rx_sh[c_nw-1:0]) * c_iw'(r_rx_sh[c_nw-1:0]);
          r_idx  <= '0;
          r_i    <= '0;
          r_j    <= '0;
          r_k    <= '0;
          r_acc  <= '0;
          r_bsel <= '0;
          r_last <= 1'b0;
        end
        LOAD_A, LOAD_B: if (r_rx_valid) r_idx <= w_load_end ? '0 : r_idx + 1'b1;
        COMPUTE: begin
          if (w_k_end) begin
            r_acc <= '0;
            r_k   <= '0;
            if (w_j_end) begin
              r_j <= '0;
              r_i <= r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_acc <= w_mac;
            r_k   <= r_k + 1'b1;
          end
        end
        SEND: if (w_tx_ready && w_tx_go) begin
          if (r_bsel == 2'd2) begin
            r_bsel <= '0;
            if (w_load_end) r_last <= 1'b1;
            else            r_idx  <= r_idx + 1'b1;
          end else begin
            r_bsel <= r_bsel + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Matrix storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (r_state == LOAD_A && r_rx_valid) r_mem_a[r_idx] <= r_rx_sh;
    if (r_state == LOAD_B && r_rx_valid) r_mem_b[r_idx] <= r_rx_sh;
    if (r_state == COMPUTE && w_k_end)   r_mem_c[w_c_addr] <= w_mac;
  end
endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_top : self-checking bench for the UART matrix multiplier.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_top;
  localparam int CLK_HZ = 200000;
  localparam int MAX_N  = 10;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       rx    = 1'b1;
  logic [1:0] b_sel = 2'b01;
  logic       tx;

  top #(.CLK_HZ(CLK_HZ), .MAX_N(MAX_N)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .b_sel(b_sel),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cur_p;
  longint      cyc = 0;
  logic [7:0]  got_q[$];
  longint      got_t[$];
  int          got_low[$];
  logic        got_stop[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  ma[100];
  logic [7:0]  mb[100];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int period(input logic [1:0] s);
    return CLK_HZ / (2400 << s);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Decodes every tx frame independently of the design, by bit-period arithmetic.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && tx === 1'b0) begin
        int p, low;
        logic seen, st;
        logic [7:0] d;
        longint t0;
        p = cur_p; t0 = cyc; low = 0; seen = 1'b0; d = '0; st = 1'b0;
        for (int c = 0; c <= 9 * p + p / 2; c++) begin
          if (c > 0) @(negedge clk);
          if (!seen) begin
            if (tx === 1'b1) seen = 1'b1;
            else low++;
          end
          for (int k = 0; k < 8; k++) if (c == (k + 1) * p + p / 2) d[k] = tx;
          if (c == 9 * p + p / 2) st = tx;
        end
        got_q.push_back(d);
        got_t.push_back(t0);
        got_low.push_back(low);
        got_stop.push_back(st);
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (cur_p) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(b[k]);
    drive_bit(stop_ok);
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (2 * cur_p) @(negedge clk);
    end
  endtask

  task automatic set_baud(input logic [1:0] s);
    b_sel = s;
    cur_p = period(s);
  endtask

  task automatic clear_rx_log();
    got_q.delete(); got_t.delete(); got_low.delete(); got_stop.delete();
  endtask

  // Sends N, A, B (optionally a corrupted frame before A[bad_at]) and checks C.
  task automatic run_mult(input string tag, input int n, input int bad_at);
    int waited, budget, bad_stop, first_odd;
    longint dmin, dmax, d;
    exp_q.delete();
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < n; k++) s += int'(ma[i * n + k]) * int'(mb[k * n + j]);
        exp_q.push_back(8'((s >> 16) & 255));
        exp_q.push_back(8'((s >> 8) & 255));
        exp_q.push_back(8'(s & 255));
      end
    clear_rx_log();
    send_byte(8'(n), 1'b1);
    for (int m = 0; m < n * n; m++) begin
      if (m == bad_at) send_byte(8'h55, 1'b0);
      send_byte(ma[m], 1'b1);
    end
    for (int m = 0; m < n * n; m++) send_byte(mb[m], 1'b1);
    budget = n * n * n + n * n + 30 * n * n * cur_p + 30 * cur_p;
    waited = 0;
    while (got_q.size() < exp_q.size() && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    repeat (12 * cur_p) @(negedge clk);
    check({tag, " byte_count"}, got_q.size(), exp_q.size());
    for (int m = 0; m < got_q.size() && m < exp_q.size(); m++)
      check($sformatf("%s byte%0d", tag, m), got_q[m], exp_q[m]);
    bad_stop = 0;
    foreach (got_stop[m]) if (got_stop[m] !== 1'b1) bad_stop++;
    check({tag, " stop_bits_low"}, bad_stop, 0);
    if (got_t.size() > 1) begin
      dmin = 64'h7fffffff; dmax = 0;
      for (int m = 1; m < got_t.size(); m++) begin
        d = got_t[m] - got_t[m - 1];
        if (d < dmin) dmin = d;
        if (d > dmax) dmax = d;
      end
      check({tag, " frame_spacing_min"}, dmin, 10 * cur_p);
      check({tag, " frame_spacing_max"}, dmax, 10 * cur_p);
    end
    first_odd = -1;
    for (int m = 0; m < exp_q.size() && m < got_low.size(); m++)
      if (first_odd < 0 && exp_q[m][0]) first_odd = m;
    if (first_odd >= 0) check({tag, " start_bit_len"}, got_low[first_odd], cur_p);
  endtask

  initial begin
    set_baud(2'b01);
    repeat (5) @(negedge clk);
    check("reset_tx_high", tx, 1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_tx_high", tx, 1'b1);

    // 4800 baud single element
    ma[0] = 8'h03; mb[0] = 8'h05;
    run_mult("n1_4800", 1, -1);

    set_baud(2'b11);
    ma[0:3] = '{8'h01, 8'h02, 8'h03, 8'h04};
    mb[0:3] = '{8'h05, 8'h06, 8'h07, 8'h08};
    run_mult("n2", 2, -1);

    for (int m = 0; m < 100; m++) begin ma[m] = 8'hFF; mb[m] = 8'hFF; end
    run_mult("n10_ff", 10, -1);

    // Out-of-range sizes are ignored
    send_byte(8'h00, 1'b1);
    send_byte(8'h0B, 1'b1);
    ma[0] = 8'h02; mb[0] = 8'h02;
    run_mult("after_bad_n", 1, -1);

    // Reset in the middle of loading B
    clear_rx_log();
    send_byte(8'd2, 1'b1);
    for (int m = 0; m < 4; m++) send_byte(8'(m + 1), 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h06, 1'b1);
    rst = 1'b0;
    repeat (3 * cur_p) @(negedge clk);
    check("tx_in_reset", tx, 1'b1);
    rst = 1'b1;
    repeat (15 * cur_p) @(negedge clk);
    check("no_output_after_reset", got_q.size(), 0);
    check("tx_after_reset", tx, 1'b1);
    ma[0] = 8'h07; mb[0] = 8'h06;
    run_mult("post_reset", 1, -1);

    // Framing error inside LOAD_A
    ma[0:3] = '{8'h10, 8'h20, 8'h30, 8'h40};
    mb[0:3] = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_mult("framing_err", 2, 2);

    // Random matrices
    begin
      int rn;
      rn = $urandom_range(3, 2);
      for (int m = 0; m < rn * rn; m++) begin
        ma[m] = 8'($urandom);
        mb[m] = 8'($urandom);
      end
      run_mult("random", rn, -1);
    end

    ma[0] = 8'hFF; mb[0] = 8'hFF;
    run_mult("n1_19200", 1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
